// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the block RAM.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ram_arbiter_if #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 16
);
  logic                     req_0;
  logic                     write_0;
  logic [ADDRESS_WIDTH-1:0] address_0;
  logic [DATA_WIDTH-1:0]    data_in_0;
  logic [DATA_WIDTH-1:0]    data_out_0;
  logic                     ack_0;

  logic                     req_1;
  logic                     write_1;
  logic [ADDRESS_WIDTH-1:0] address_1;
  logic [DATA_WIDTH-1:0]    data_in_1;
  logic [DATA_WIDTH-1:0]    data_out_1;
  logic                     ack_1;

  logic [ADDRESS_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0]    ram_data_in;
  logic                     ram_write_enable;
  logic [DATA_WIDTH-1:0]    ram_data_out;

  logic                     busy;
  logic                     grant;

  modport slave (
    input  req_0, write_0, address_0, data_in_0,
    input  req_1, write_1, address_1, data_in_1,
    input  ram_data_out,
    output data_out_0, ack_0, data_out_1, ack_1,
    output ram_address, ram_data_in, ram_write_enable,
    output busy, grant
  );

  modport master (
    output req_0, write_0, address_0, data_in_0,
    output req_1, write_1, address_1, data_in_1,
    output ram_data_out,
    input  data_out_0, ack_0, data_out_1, ack_1,
    input  ram_address, ram_data_in, ram_write_enable,
    input  busy, grant
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port fair arbiter in front of a single-port registered block RAM.
// Each transaction takes four cycles: IDLE -> ACCESS -> CAPTURE -> DONE.
module ram_arbiter #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 16
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  state_t                   state;
  state_t                   state_next;
  logic                     winner;
  logic                     any_req;

  logic                     grant;
  logic                     write_op;
  logic                     ack_0;
  logic                     ack_1;
  logic                     busy;
  logic                     ram_write_enable;
  logic [ADDRESS_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0]    ram_data_in;
  logic [DATA_WIDTH-1:0]    data_out_0;
  logic [DATA_WIDTH-1:0]    data_out_1;

  // On contention the port that did not win last time gets the RAM.
  always_comb begin
    state_next = state;
    any_req    = bus.req_0 | bus.req_1;
    winner     = (bus.req_0 & bus.req_1) ? ~grant : bus.req_1;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = CAPTURE;
      CAPTURE: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      grant            <= 1'b1;
      write_op         <= 1'b0;
      ack_0            <= 1'b0;
      ack_1            <= 1'b0;
      busy             <= 1'b0;
      ram_write_enable <= 1'b0;
      ram_address      <= '0;
      ram_data_in      <= '0;
      data_out_0       <= '0;
      data_out_1       <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (any_req) begin
            grant            <= winner;
            write_op         <= winner ? bus.write_1   : bus.write_0;
            ram_write_enable <= winner ? bus.write_1   : bus.write_0;
            ram_address      <= winner ? bus.address_1 : bus.address_0;
            ram_data_in      <= winner ? bus.data_in_1 : bus.data_in_0;
          end else begin
            ram_write_enable <= 1'b0;
          end
        end
        ACCESS: ram_write_enable <= 1'b0;
        // RAM output is valid now, one cycle after the access edge.
        CAPTURE: begin
          if (grant) begin
            ack_1 <= 1'b1;
            if (!write_op) data_out_1 <= bus.ram_data_out;
          end else begin
            ack_0 <= 1'b1;
            if (!write_op) data_out_0 <= bus.ram_data_out;
          end
        end
        DONE: begin
          ack_0 <= 1'b0;
          ack_1 <= 1'b0;
        end
        default: ram_write_enable <= 1'b0;
      endcase
    end
  end

  assign bus.grant            = grant;
  assign bus.busy             = busy;
  assign bus.ack_0            = ack_0;
  assign bus.ack_1            = ack_1;
  assign bus.data_out_0       = data_out_0;
  assign bus.data_out_1       = data_out_1;
  assign bus.ram_address      = ram_address;
  assign bus.ram_data_in      = ram_data_in;
  assign bus.ram_write_enable = ram_write_enable;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural 1024x16 registered RAM, directed steps,
// and a scoreboard of expected acknowledges checked as they appear.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDRESS_WIDTH(10), .DATA_WIDTH(16)) bus();

  ram_arbiter #(.ADDRESS_WIDTH(10), .DATA_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          port;
    bit          wr;
    logic [15:0] data;
  } entry_t;

  entry_t      sb[$];
  logic [15:0] mem    [1024];
  logic [15:0] shadow [1024];
  logic [15:0] rdata;
  logic [15:0] exp_dout [2];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  logic [9:0]  we_addr;
  logic [15:0] we_data;

  assign bus.ram_data_out = rdata;

  function automatic logic [15:0] init_word(int i);
    return 16'(i * 37) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (bus.ram_write_enable) mem[bus.ram_address] <= bus.ram_data_in;
    rdata <= mem[bus.ram_address];
  end

  // Acknowledge monitor: pops the scoreboard and checks both ports' outputs.
  always @(negedge clk) begin
    if (bus.ram_write_enable) begin
      we_cnt++;
      we_addr = bus.ram_address;
      we_data = bus.ram_data_in;
    end
    if (!reset) begin
      exp_dout[0] = '0;
      exp_dout[1] = '0;
    end else if (bus.ack_0 || bus.ack_1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'({bus.ack_1, bus.ack_0}), 32'd0);
      end else begin
        entry_t e;
        e = sb.pop_front();
        chk("ack_port", 32'({bus.ack_1, bus.ack_0}), (e.port == 1) ? 32'd2 : 32'd1);
        chk("ack_grant", 32'(bus.grant), 32'(e.port));
        if (!e.wr) exp_dout[e.port] = e.data;
        chk("data_out_0", 32'(bus.data_out_0), 32'(exp_dout[0]));
        chk("data_out_1", 32'(bus.data_out_1), 32'(exp_dout[1]));
      end
    end
  end

  task automatic set_fields(input int port, input bit wr, input logic [9:0] a, input logic [15:0] d);
    entry_t e;
    if (port == 0) begin
      bus.write_0 = wr; bus.address_0 = a; bus.data_in_0 = d;
    end else begin
      bus.write_1 = wr; bus.address_1 = a; bus.data_in_1 = d;
    end
    e.port = port;
    e.wr   = wr;
    if (wr) begin
      shadow[a] = d;
      e.data = d;
    end else begin
      e.data = shadow[a];
    end
    sb.push_back(e);
  endtask

  task automatic wait_ack(input int port, output int edges);
    logic got;
    got = 1'b0;
    edges = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      edges++;
      #1;
      got = (port == 0) ? bus.ack_0 : bus.ack_1;
    end
    chk($sformatf("ack_timeout_p%0d", port), 32'(got), 32'd1);
  endtask

  task automatic do_txn(input int port, input bit wr, input logic [9:0] a, input logic [15:0] d,
                        output int edges);
    set_fields(port, wr, a, d);
    if (port == 0) bus.req_0 = 1'b1; else bus.req_1 = 1'b1;
    wait_ack(port, edges);
    if (port == 0) bus.req_0 = 1'b0; else bus.req_1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    int wb;
    int n;
    int k0;
    int k1;
    int t0 [2];
    int t1 [2];

    for (int i = 0; i < 1024; i++) begin
      mem[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
    bus.req_0 = 1'b1; bus.write_0 = 1'b1; bus.address_0 = 10'h0AA; bus.data_in_0 = 16'hFFFF;
    bus.req_1 = 1'b1; bus.write_1 = 1'b1; bus.address_1 = 10'h0BB; bus.data_in_1 = 16'hEEEE;

    // Reset held with both requests active.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack_0", 32'(bus.ack_0), 32'd0);
    chk("rst_ack_1", 32'(bus.ack_1), 32'd0);
    chk("rst_we", 32'(bus.ram_write_enable), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_addr", 32'(bus.ram_address), 32'd0);
    chk("rst_din", 32'(bus.ram_data_in), 32'd0);
    chk("rst_dout_0", 32'(bus.data_out_0), 32'd0);
    chk("rst_dout_1", 32'(bus.data_out_1), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd1);
    chk("rst_we_cnt", 32'(we_cnt), 32'd0);

    // Release: port 0 must win the first contest.
    set_fields(0, 1'b0, 10'h0AA, 16'h0000);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("first_grant", 32'(bus.grant), 32'd0);
    chk("first_busy", 32'(bus.busy), 32'd1);
    chk("first_we", 32'(bus.ram_write_enable), 32'd0);
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    wait_ack(0, edges);
    @(posedge clk);
    #1;

    // Port 0 write then read back.
    wb = we_cnt;
    do_txn(0, 1'b1, 10'h155, 16'hA5C3, edges);
    chk("wr_we_cnt", 32'(we_cnt - wb), 32'd1);
    chk("wr_we_addr", 32'(we_addr), 32'h155);
    chk("wr_we_data", 32'(we_data), 32'hA5C3);
    wb = we_cnt;
    do_txn(0, 1'b0, 10'h155, 16'h0000, edges);
    chk("rd_latency", 32'(edges), 32'd3);
    chk("rd_we_cnt", 32'(we_cnt - wb), 32'd0);
    chk("rd_dout_0", 32'(bus.data_out_0), 32'hA5C3);

    // Request fields change after grant are ignored.
    set_fields(1, 1'b0, 10'h010, 16'h0000);
    bus.req_1 = 1'b1;
    @(posedge clk);
    #1;
    chk("fc_grant", 32'(bus.grant), 32'd1);
    chk("fc_addr_access", 32'(bus.ram_address), 32'h010);
    bus.address_1 = 10'h020;
    @(posedge clk);
    #1;
    chk("fc_addr_capture", 32'(bus.ram_address), 32'h010);
    wait_ack(1, edges);
    bus.req_1 = 1'b0;
    @(posedge clk);
    #1;

    // Both ports hold requests: strict alternation 0,1,0,1.
    set_fields(0, 1'b0, 10'h155, 16'h0000);
    set_fields(1, 1'b0, 10'h3FF, 16'h0000);
    set_fields(0, 1'b0, 10'h155, 16'h0000);
    set_fields(1, 1'b0, 10'h3FF, 16'h0000);
    bus.req_0 = 1'b1;
    bus.req_1 = 1'b1;
    n = 0; k0 = 0; k1 = 0;
    t0[0] = 0; t0[1] = 0; t1[0] = 0; t1[1] = 0;
    for (int i = 0; i < 60 && k1 < 2; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.ack_0 && k0 < 2) begin t0[k0] = n; k0++; end
      if (bus.ack_1 && k1 < 2) begin t1[k1] = n; k1++; end
    end
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    chk("sim_acks_1", 32'(k1), 32'd2);
    chk("sim_first_ack0", 32'(t0[0]), 32'd3);
    chk("sim_period_0", 32'(t0[1] - t0[0]), 32'd8);
    chk("sim_period_1", 32'(t1[1] - t1[0]), 32'd8);
    chk("sim_offset", 32'(t1[0] - t0[0]), 32'd4);
    chk("sim_dout_1", 32'(bus.data_out_1), 32'(init_word(10'h3FF)));
    @(posedge clk);
    #1;

    // Reset during the ACCESS cycle of a port 1 write.
    set_fields(1, 1'b1, 10'h2AA, 16'h1234);
    void'(sb.pop_back());
    wb = we_cnt;
    bus.req_1 = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_we_access", 32'(bus.ram_write_enable), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_we_after", 32'(bus.ram_write_enable), 32'd0);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_ack_1", 32'(bus.ack_1), 32'd0);
    chk("mr_grant", 32'(bus.grant), 32'd1);
    chk("mr_dout_0", 32'(bus.data_out_0), 32'd0);
    bus.req_1 = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mr_ack_1_late", 32'(bus.ack_1), 32'd0);
    chk("mr_we_cnt", 32'(we_cnt - wb), 32'd1);

    // Port 0 holds req one cycle past ack with new fields.
    set_fields(0, 1'b0, 10'h155, 16'h0000);
    bus.req_0 = 1'b1;
    wait_ack(0, edges);
    chk("hold_latency", 32'(edges), 32'd3);
    set_fields(0, 1'b0, 10'h0AB, 16'h0000);
    @(posedge clk);
    #1;
    chk("hold_done_busy", 32'(bus.busy), 32'd0);
    chk("hold_done_ack", 32'(bus.ack_0), 32'd0);
    @(posedge clk);
    #1;
    chk("hold_busy", 32'(bus.busy), 32'd1);
    chk("hold_addr", 32'(bus.ram_address), 32'h0AB);
    chk("hold_grant", 32'(bus.grant), 32'd0);
    bus.req_0 = 1'b0;
    wait_ack(0, edges);
    chk("hold_second_edges", 32'(edges), 32'd2);
    chk("hold_dout_0", 32'(bus.data_out_0), 32'(init_word(10'h0AB)));

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port on-chip 1024x16 block RAM between two requesters.
  - Port 0: the F100-L CPU core.
  - Port 1: the UART program loader / debug monitor.
- Sits between the requesters and the RAM instance. Sequences the RAM's one-cycle registered read and write-or-read access.
- Returns read data with a per-port acknowledge pulse. Alternates grants fairly when both ports request.

Parameters:
- ADDRESS_WIDTH, 10, RAM word-address width.
- DATA_WIDTH, 16, RAM word width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- req_0  input  1  port 0 access request; level, held until ack_0 is sampled.
- write_0  input  1  port 0: 1 = write, 0 = read.
- address_0  input  ADDRESS_WIDTH  port 0 word address.
- data_in_0  input  DATA_WIDTH  port 0 write data.
- data_out_0  output  DATA_WIDTH  port 0 read data; valid while ack_0 = 1.
- ack_0  output  1  port 0 completion; one-cycle pulse.
- req_1, write_1, address_1, data_in_1, data_out_1, ack_1: same as port 0, for port 1.
- ram_address  output  ADDRESS_WIDTH  to RAM address.
- ram_data_in  output  DATA_WIDTH  to RAM data_in.
- ram_write_enable  output  1  to RAM write_enable.
- ram_data_out  input  DATA_WIDTH  from RAM data_out; registered in the RAM, valid the cycle after the RAM edge.
- busy  output  1  1 whenever state != IDLE.
- grant  output  1  index of the port owning the current or most recent transaction.

Behaviour:
- Reset (reset = 0 at a rising edge), values on the next cycle:
  - state = IDLE.
  - ack_0 = ack_1 = 0, ram_write_enable = 0, busy = 0.
  - ram_address = 0, ram_data_in = 0, data_out_0 = data_out_1 = 0.
  - grant = 1, so port 0 wins the first contest.
- Reset applies mid-transaction: any pending access is abandoned, no ack is issued, and ram_write_enable is 0 the cycle after.
- All outputs are registered.
- State machine (one transaction per 4 cycles):
  - IDLE: if any req is high, pick the winner.
    - Register ram_address, ram_data_in and ram_write_enable = write_x from the winner; set grant to the winner; go to ACCESS.
    - Otherwise stay in IDLE with ram_write_enable = 0.
  - ACCESS: the RAM performs the operation at this edge. Clear ram_write_enable; go to CAPTURE.
  - CAPTURE:
    - Read: latch ram_data_out into data_out_<grant>.
    - Write: data_out_<grant> keeps its previous value.
    - Set ack_<grant> = 1; go to DONE.
  - DONE: ack is high during this cycle. Clear ack; go to IDLE. req inputs are ignored in DONE.
- Latency: req sampled at edge E0 -> ack_x high in the cycle following edge E2. The requester must drop req at or before edge E3, otherwise a new transaction starts at E4.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: the port != grant (the last winner) wins, i.e. strict alternation, no starvation.
- Request fields (write, address, data_in) are sampled only at grant; changes afterwards are ignored.
- Only the granted port's data_out and ack change; the other port's outputs hold.
- ram_write_enable is high for exactly one cycle per write, never for reads.
- Addresses pass through unmodified; no wrap or range check (full 10-bit space).

Test Plan:
- Reset: hold reset = 0 for 2 cycles with req_0 = req_1 = 1.
  -> All outputs 0, grant = 1, no ram_write_enable. Release -> port 0 granted first.
- Port 0 write then read: write 16'hA5C3 to address 10'h155, then read the same address.
  -> ram_write_enable high exactly one cycle with ram_address = 10'h155.
  -> Read ack_0 arrives 3 edges after req, with data_out_0 = 16'hA5C3.
- Simultaneous requests: both ports hold req continuously, port 1 reading address 10'h3FF.
  -> Grants alternate 0,1,0,1.
  -> Each ack arrives every 8 cycles.
  -> data_out_1 = the contents of 10'h3FF.
- Field change after grant: port 1 changes address_1 from 10'h010 to 10'h020 in ACCESS.
  -> RAM is accessed at 10'h010 only.
- Reset mid-write: assert reset during ACCESS of a port 1 write.
  -> No ack_1. ram_write_enable = 0 the next cycle. busy = 0.
- Held req after ack: port 0 keeps req high one cycle past ack.
  -> The DONE cycle ignores it; a second transaction starts from IDLE with the correct fields.
